// File: rtl/dmem_copy_engine_if.sv
// dmem_copy_engine_if
//
// Purpose: single-port synchronous data-memory bus between the copy engine
// (master) and the data memory (slave).
//
// Signals:
//   mem_address  - word address, driven by the master
//   mem_data_in  - write data, driven by the master
//   mem_write_en - write enable, driven by the master
//   mem_data_out - registered read data from the memory, valid one cycle
//                  after its address was presented
//
// Modports:
//   master - the copy engine
//   slave  - the memory

interface dmem_copy_engine_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output mem_address,
        output mem_data_in,
        output mem_write_en,
        input  mem_data_out
    );

    modport slave (
        input  mem_address,
        input  mem_data_in,
        input  mem_write_en,
        output mem_data_out
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine
//
// Purpose: single-channel block-copy initiator. On an accepted start it
// copies len words from src_addr upward to dst_addr upward through the
// single data-memory port, one word every two cycles (RD then WR), and
// pulses done for one cycle at the end. Addresses wrap modulo 2^ADDR_W and
// the copy is strictly forward, so overlapping ranges with dst > src
// propagate already-written words.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high reset
//   start    - command strobe, sampled only in IDLE
//   src_addr - first source word address (latched on accepted start)
//   dst_addr - first destination word address (latched on accepted start)
//   len      - word count 0..2^ADDR_W (latched on accepted start)
//   busy     - high while reading/writing
//   done     - one-cycle completion pulse
//   checksum - running sum of copied words (0 unless built with checksum)
//   mem      - memory bus, master side
//
// Build option:
//   DMEM_COPY_CHECKSUM_EN - when defined, checksum accumulates every word
//   written, clears on an accepted start and holds after done. When not
//   defined, no accumulator is built and checksum is tied to zero.

module dmem_copy_engine #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   checksum,
    dmem_copy_engine_if.master  mem
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } state_e;

    localparam logic [ADDR_W:0] LenOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LenZero = '0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // One bit wider than the index so i+1 == len works for len = 2^ADDR_W.
    logic [ADDR_W:0]   idx_next;

    assign idx_next = {1'b0, idx_q} + LenOne;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != LenZero) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        idx_d   = '0;
                        state_d = StRd;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRd: begin
                state_d = StWr;
            end
            StWr: begin
                if (idx_next == len_q) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_next[ADDR_W-1:0];
                    state_d = StRd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from registered state only; the one combinational path
    // from the memory is read data forwarded to write data during WR.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem.mem_address  = '0;
        mem.mem_data_in  = '0;
        mem.mem_write_en = 1'b0;
        unique case (state_q)
            StRd: begin
                busy            = 1'b1;
                mem.mem_address = src_q + idx_q;
            end
            StWr: begin
                busy             = 1'b1;
                mem.mem_address  = dst_q + idx_q;
                mem.mem_data_in  = mem.mem_data_out;
                mem.mem_write_en = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == StIdle && start) begin
            sum_q <= '0;
        end else if (state_q == StWr) begin
            sum_q <= sum_q + mem.mem_data_out;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine
//
// Purpose: self-checking bench for dmem_copy_engine. A behavioural memory
// (one-cycle registered read) hangs off the bus; a reference image of the
// memory is updated by a plain forward word-by-word copy loop, and the port
// activity of every cycle is compared against the RD/WR schedule.

module tb_dmem_copy_engine;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 64;
    localparam int          DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    int errors = 0;
    int checks = 0;

    dmem_copy_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    dmem_copy_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // Memory model with a bench-side preload port.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_bus.mem_write_en) mem[mem_bus.mem_address] <= mem_bus.mem_data_in;
        rdata_q <= mem[mem_bus.mem_address];
    end

    assign mem_bus.mem_data_out = rdata_q;

    // Event counters sampled at the active edge.
    int done_cnt = 0;
    int we_cnt   = 0;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (mem_bus.mem_write_en === 1'b1) we_cnt <= we_cnt + 1;
    end

    logic [DATA_W-1:0] ref_mem [DEPTH];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Issues one command and follows it cycle by cycle. Cycle n is the
    // n-th cycle after the start edge: odd n < 2*len+1 reads word (n-1)/2,
    // even n writes word n/2-1, cycle 2*len+1 is the done pulse.
    // pulse_at > 0 raises start again during that cycle; reset_at > 0
    // asserts reset during that (WR) cycle and abandons the command.
    task automatic run_copy(input string tag, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input logic [ADDR_W:0] l,
                            input int pulse_at, input int reset_at, output int done_at);
        int                d0, w0, last, k;
        logic [DATA_W-1:0] sum, v, exp_sum;
        logic [ADDR_W-1:0] a, kk;
        logic [127:0]      expv;
        d0      = done_cnt;
        w0      = we_cnt;
        sum     = '0;
        done_at = -1;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        last = 2 * int'(l) + 1;
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            start = (n == pulse_at);
            if (n == pulse_at) begin
                src_addr = 8'd0;
                dst_addr = 8'd100;
                len      = 9'd3;
            end
            v = '0;
            if (n == last) begin
                expv = {1'b0, 1'b1, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
            end else if (n % 2 == 1) begin
                k    = (n - 1) / 2;
                kk   = k[ADDR_W-1:0];
                a    = s + kk;
                expv = {1'b1, 1'b0, 1'b0, a, {DATA_W{1'b0}}};
            end else begin
                k    = n / 2 - 1;
                kk   = k[ADDR_W-1:0];
                a    = s + kk;
                v    = ref_mem[a];
                a    = d + kk;
                expv = {1'b1, 1'b0, 1'b1, a, v};
            end
            if (done === 1'b1 && done_at < 0) done_at = n;
            chk($sformatf("%s_cycle%0d", tag, n),
                {busy, done, mem_bus.mem_write_en, mem_bus.mem_address, mem_bus.mem_data_in},
                expv);
            if (n % 2 == 0 && n != last) begin
                if (n == reset_at) begin
                    reset = 1'b1;
                    #1;
                    chk({tag, "_reset_outputs"},
                        {busy, done, mem_bus.mem_write_en, mem_bus.mem_address,
                         mem_bus.mem_data_in, checksum}, '0);
                    repeat (4) @(negedge clk);
                    chk({tag, "_reset_no_done"}, done_cnt - d0, 0);
                    chk({tag, "_reset_writes"}, we_cnt - w0, reset_at / 2 - 1);
                    reset = 1'b0;
                    mem_compare({tag, "_reset_mem"});
                    return;
                end
                ref_mem[a] = v;
                sum        = sum + v;
            end
        end
        @(negedge clk);
        chk({tag, "_idle_after"}, {busy, done, mem_bus.mem_write_en, mem_bus.mem_address}, '0);
`ifdef DMEM_COPY_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
        chk({tag, "_checksum"}, checksum, exp_sum);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_write_count"}, we_cnt - w0, int'(l));
        mem_compare({tag, "_mem"});
    endtask

    logic [DATA_W-1:0] plan_vals [5];
    int                done_at;
    logic [ADDR_W-1:0] rs, rd;
    logic [ADDR_W:0]   rl;
    logic [DATA_W-1:0] sum_ref;

    initial begin
        plan_vals = '{64'd3, 64'd5, 64'd1, 64'd2, 64'd4};
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        #1;
        chk("reset_state",
            {busy, done, mem_bus.mem_write_en, mem_bus.mem_address,
             mem_bus.mem_data_in, checksum}, '0);

        // Random memory image, loaded while the engine is held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            poke(i[ADDR_W-1:0], {$urandom, $urandom});
        end
        @(negedge clk);
        reset = 1'b0;

        // Basic copy 0..4 -> 10..14.
        for (int i = 0; i < 5; i++) poke(i[ADDR_W-1:0], plan_vals[i]);
        run_copy("basic", 8'd0, 8'd10, 9'd5, 0, 0, done_at);
        chk("basic_done_at", done_at, 11);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("basic_dst%0d", i), mem[10 + i], plan_vals[i]);
            chk($sformatf("basic_src%0d", i), mem[i], plan_vals[i]);
        end
`ifdef DMEM_COPY_CHECKSUM_EN
        sum_ref = 64'd15;
`else
        sum_ref = 64'd0;
`endif
        chk("basic_checksum15", checksum, sum_ref);

        // Zero-length command.
        run_copy("len0", 8'd30, 8'd31, 9'd0, 0, 0, done_at);
        chk("len0_done_at", done_at, 1);

        // Wrap: word 2 receives whatever word 0 holds when it is read in
        // cycle 5, i.e. the 0xA written there in cycle 2.
        poke(8'd254, 64'hA);
        poke(8'd255, 64'hB);
        run_copy("wrap", 8'd254, 8'd0, 9'd3, 0, 0, done_at);
        chk("wrap_w0", mem[0], 64'hA);
        chk("wrap_w1", mem[1], 64'hB);
        chk("wrap_w2", mem[2], 64'hA);

        // Overlap with dst > src propagates the first word.
        poke(8'd0, 64'd7);
        poke(8'd1, 64'd8);
        poke(8'd2, 64'd9);
        run_copy("overlap", 8'd0, 8'd1, 9'd2, 0, 0, done_at);
        chk("overlap_w1", mem[1], 64'd7);
        chk("overlap_w2", mem[2], 64'd7);

        // Start pulse during a busy copy is ignored.
        run_copy("pulse", 8'd20, 8'd40, 9'd5, 3, 0, done_at);

        // Reset during WR of word 2, then a fresh command.
        run_copy("abort", 8'd50, 8'd60, 9'd5, 0, 6, done_at);
        chk("abort_w3_untouched", mem[63], ref_mem[63]);
        run_copy("after_reset", 8'd50, 8'd60, 9'd5, 0, 0, done_at);

        // Randomized commands, plus one full-depth copy.
        for (int t = 0; t < 6; t++) begin
            rs = $urandom_range(0, DEPTH - 1);
            rd = $urandom_range(0, DEPTH - 1);
            rl = $urandom_range(1, 24);
            run_copy($sformatf("rand%0d", t), rs, rd, rl, 0, 0, done_at);
        end
        rs = $urandom_range(0, DEPTH - 1);
        rd = $urandom_range(0, DEPTH - 1);
        run_copy("full", rs, rd, 9'd256, 0, 0, done_at);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
